// File: rtl/sha256_block_shifter.sv
// Serial transmit end of the rolled SHA-256 transform: stages one block and shifts it
// out MSB first, locked to the ready pulse. Define SHA_SHIFT_NONCE_INC_EN to enable nonce re-send.
module sha256_block_shifter #(
    parameter int BLOCK_W   = 512,
    parameter int ROUND_CYC = 64,
    parameter int NONCE_LSB = 384
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sync_in,
    input  logic               load_valid,
    output logic               load_ready,
    input  logic [BLOCK_W-1:0] load_data,
    output logic               tx_shift,
    output logic               busy,
    output logic               block_start,
    output logic               block_done,
    output logic               underrun
);
    localparam int               CNT_W    = $clog2(BLOCK_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [0:0]       S_IDLE   = 1'b0;
    localparam logic [0:0]       S_SHIFT  = 1'b1;

    if ((BLOCK_W % ROUND_CYC) != 0 || (NONCE_LSB + 32) > BLOCK_W) begin : g_bad_params
        $error("sha256_block_shifter: BLOCK_W, ROUND_CYC and NONCE_LSB are inconsistent");
    end

    logic [0:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic               staged_full;
    logic [BLOCK_W-1:0] staged;
    logic [BLOCK_W-1:0] sreg;
    logic [BLOCK_W-1:0] next_blk;
    logic               shifting;
    logic               at_end;
    logic               take;
    logic               load_fire;

    // cnt runs 1..BLOCK_W; the final count is the completion cycle, not a data bit.
    assign shifting   = (state == S_SHIFT) && (cnt != CNT_LAST);
    assign at_end     = (state == S_SHIFT) && (cnt == CNT_LAST);
    assign load_ready = !staged_full;
    assign load_fire  = load_valid && !staged_full;

`ifdef SHA_SHIFT_NONCE_INC_EN
    logic [BLOCK_W-1:0] last_blk;

    // NOTE: next_blk gets a full default first, so no path can leave it unassigned (no latch).
    always_comb begin
        next_blk                  = last_blk;
        next_blk[NONCE_LSB +: 32] = last_blk[NONCE_LSB +: 32] + 32'd1;
        if (staged_full) next_blk = staged;
    end

    assign take = (staged_full && sync_in && (state == S_IDLE)) || at_end;
`else
    assign next_blk = staged;
    assign take     = staged_full && ((sync_in && (state == S_IDLE)) || at_end);
`endif

    // The first bit of a new block is driven combinationally in its start cycle.
    assign block_start = take;
    assign block_done  = at_end;
    assign busy        = take || shifting;
    assign tx_shift    = take ? next_blk[BLOCK_W-1] : (shifting && sreg[BLOCK_W-1]);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            staged_full <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            if (load_fire) begin
                staged_full <= 1'b1;
            end else if (take) begin
                staged_full <= 1'b0;
            end

            if (take) begin
                state <= S_SHIFT;
                cnt   <= CNT_ONE;
            end else if (at_end) begin
                state    <= S_IDLE;
                cnt      <= '0;
                underrun <= 1'b1;
            end else if (shifting) begin
                cnt <= cnt + CNT_ONE;
            end
        end
    end

    // NOTE: wide data registers carry no reset; control flags alone decide when they are meaningful.
    always_ff @(posedge clk) begin
        if (load_fire) staged <= load_data;
        if (take) begin
            sreg <= next_blk << 1;
        end else begin
            sreg <= sreg << 1;
        end
`ifdef SHA_SHIFT_NONCE_INC_EN
        if (take) last_blk <= next_blk;
`endif
    end
endmodule

// File: tb/tb_sha256_block_shifter.sv
// Self-checking bench for sha256_block_shifter: directed scenarios plus random blocks,
// checked cycle by cycle against a queue-based model of the serial block stream.
module tb_sha256_block_shifter;
    localparam int BW    = 512;
    localparam int ROUND = 64;
    localparam int NL    = 384;
`ifdef SHA_SHIFT_NONCE_INC_EN
    localparam bit NONCE_EN = 1'b1;
`else
    localparam bit NONCE_EN = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          sync_in;
    logic          load_valid;
    logic          load_ready;
    logic [BW-1:0] load_data;
    logic          tx_shift;
    logic          busy;
    logic          block_start;
    logic          block_done;
    logic          underrun;

    sha256_block_shifter #(.BLOCK_W(BW), .ROUND_CYC(ROUND), .NONCE_LSB(NL)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sync_in     (sync_in),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_data   (load_data),
        .tx_shift    (tx_shift),
        .busy        (busy),
        .block_start (block_start),
        .block_done  (block_done),
        .underrun    (underrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [BW-1:0] inc_nonce(input logic [BW-1:0] b);
        logic [BW-1:0] r;
        r            = b;
        r[NL +: 32]  = b[NL +: 32] + 32'd1;
        return r;
    endfunction

    function automatic logic [BW-1:0] rand_blk();
        logic [BW-1:0] r;
        for (int i = 0; i < BW / 32; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Reference model: accepted blocks queue up, each start takes the oldest one
    // (or the nonce-incremented previous block), and a block lasts BW cycles.
    logic [BW-1:0] pend[$];
    logic [BW-1:0] cur     = '0;
    logic [BW-1:0] rx      = '0;
    logic [BW-1:0] rx_snap = '0;
    bit            active    = 1'b0;
    bit            under_exp = 1'b0;
    int            mcnt      = 0;
    bit            e_done, e_start, e_tx;

    always @(negedge clk) begin
        if (!rst_n) begin
            pend.delete();
            active    = 1'b0;
            under_exp = 1'b0;
            mcnt      = 0;
        end else begin
            e_done  = active && (mcnt == BW);
            e_start = sync_in && (!active || e_done) && (pend.size() != 0 || (NONCE_EN && e_done));
            check("block_done", block_done, e_done);
            check("block_start", block_start, e_start);
            check("load_ready", load_ready, pend.size() == 0);
            check("underrun", underrun, under_exp);
            if (active) check("sync_align", sync_in && (mcnt % ROUND != 0), 1'b0);
            if (e_done) begin
                check("rx_block", rx, cur);
                rx_snap = rx;
                if (!e_start) begin
                    active    = 1'b0;
                    under_exp = 1'b1;
                end
            end
            if (e_start) begin
                cur    = (pend.size() != 0) ? pend.pop_front() : inc_nonce(cur);
                active = 1'b1;
                mcnt   = 0;
            end
            e_tx = active ? cur[BW-1-mcnt] : 1'b0;
            check("tx_shift", tx_shift, e_tx);
            check("busy", busy, active);
            if (active) mcnt++;
            if (load_valid && load_ready) pend.push_back(load_data);
        end
        rx = {rx[BW-2:0], tx_shift};
    end

    bit sync_en = 1'b0;
    int phase   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        sync_in = sync_en && (phase == 0);
        phase   = (phase + 1) % ROUND;
    endtask

    task automatic wait_for(input string tag, input bit want_done, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            seen = want_done ? block_done : block_start;
            if (!seen) tick();
        end
        check(tag, seen, 1'b1);
    endtask

    task automatic load_blk(input logic [BW-1:0] b);
        bit ok = 1'b0;
        load_data  = b;
        load_valid = 1'b1;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            ok = load_ready;
            tick();
        end
        load_valid = 1'b0;
        check("load_accept", ok, 1'b1);
    endtask

    logic [BW-1:0] blk_a, blk_b, blk_d, bits, tmp;
    logic [31:0]   exp_n [3];

    initial begin
        rst_n      = 1'b0;
        sync_in    = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        exp_n      = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};

        // Reset values
        repeat (2) tick();
        @(negedge clk);
        check("rst_load_ready", load_ready, 1'b1);
        check("rst_tx", tx_shift, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_start_done", {block_start, block_done}, 2'b00);
        check("rst_underrun", underrun, 1'b0);
        tick();
        rst_n = 1'b1;

        // Block held with load_valid high but no sync for 300 cycles
        blk_a          = '0;
        blk_a[BW-1]    = 1'b1;
        blk_a[0]       = 1'b1;
        blk_b          = rand_blk();
        load_data      = blk_a;
        load_valid     = 1'b1;
        repeat (300) tick();
        @(negedge clk);
        check("nosync_busy", busy, 1'b0);
        check("nosync_tx", tx_shift, 1'b0);
        check("nosync_staged", load_ready, 1'b0);
        tick();
        load_valid = 1'b0;
        sync_en    = 1'b1;
        phase      = 0;

        // First block bit by bit, second block loaded during the shift
        wait_for("start_a", 1'b0, 4);
        bits[BW-1] = tx_shift;
        for (int i = 1; i < BW; i++) begin
            tick();
            if (i == 1) begin
                load_data  = blk_b;
                load_valid = 1'b1;
            end
            if (i == 2) load_valid = 1'b0;
            @(negedge clk);
            bits[BW-1-i] = tx_shift;
        end
        check("bits_a", bits, blk_a);
        tick();
        @(negedge clk);
        check("done_a", block_done, 1'b1);
        check("start_b_no_gap", block_start, 1'b1);

        // No further load after the second block
        tick();
        wait_for("done_b", 1'b1, BW + 8);
        tick();
        @(negedge clk);
        check("after_b_underrun", underrun, !NONCE_EN);
        check("after_b_busy", busy, NONCE_EN);
        if (!NONCE_EN) check("after_b_tx", tx_shift, 1'b0);
        repeat (100) tick();
        @(negedge clk);
        check("underrun_held", underrun, !NONCE_EN);
        tick();

        // Reset 200 cycles into a shift
        load_blk(rand_blk());
        wait_for("start_c", 1'b0, BW + 80);
        repeat (200) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_tx", tx_shift, 1'b0);
        check("async_busy", busy, 1'b0);
        check("async_load_ready", load_ready, 1'b1);
        check("async_underrun", underrun, 1'b0);
        check("async_start_done", {block_start, block_done}, 2'b00);
        tick();
        rst_n = 1'b1;

        // Restart after reset; nonce near wrap
        blk_d           = rand_blk();
        blk_d[NL +: 32] = 32'hFFFF_FFFE;
        load_blk(blk_d);
        wait_for("start_d", 1'b0, ROUND + 8);
        tick();
        wait_for("done_d", 1'b1, BW + 8);
        if (NONCE_EN) begin
            for (int k = 0; k < 3; k++) begin
                tick();
                wait_for("done_resend", 1'b1, BW + 8);
                tick();
                check("resend_nonce", rx_snap[NL +: 32], exp_n[k]);
                tmp          = rx_snap;
                tmp[NL +: 32] = blk_d[NL +: 32];
                check("resend_rest", tmp, blk_d);
                check("resend_underrun", underrun, 1'b0);
            end
        end else begin
            tick();
            @(negedge clk);
            check("underrun_d", underrun, 1'b1);
        end

        // Random blocks with random gaps
        for (int r = 0; r < 6; r++) begin
            repeat ($urandom_range(0, 700)) tick();
            load_blk(rand_blk());
        end
        repeat (1200) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
